// File: rtl/riscv_mtimer_pkg.sv
// riscv_mtimer_pkg: register map, CTRL bit positions and CTRL layout for the machine timer.
// Revision: 1.0
`default_nettype none

package riscv_mtimer_pkg;

    localparam logic [4:0] ADDR_CTRL        = 5'h00;
    localparam logic [4:0] ADDR_PRESCALE    = 5'h04;
    localparam logic [4:0] ADDR_MTIMECMP_LO = 5'h08;
    localparam logic [4:0] ADDR_MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] ADDR_MTIME_LO    = 5'h10;
    localparam logic [4:0] ADDR_MTIME_HI    = 5'h14;

    localparam int CTRL_TICK_EN_BIT = 0;
    localparam int CTRL_IRQ_EN_BIT  = 1;

    typedef struct packed {
        logic irq_en;
        logic tick_en;
    } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/riscv_prescaler.sv
// riscv_prescaler: programmable divider producing a registered one-cycle tick every divider+1 cycles.
// Revision: 1.0
`default_nettype none

module riscv_prescaler #(
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [PRESCALE_WIDTH-1:0] divider,
    input  logic                      clear,
    output logic                      tick
);

    logic [PRESCALE_WIDTH-1:0] count;

    // clear wins over a terminal count so a divider change never emits a stray tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (!enable || clear) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (count == divider) begin
            count <= '0;
            tick  <= 1'b1;
        end else begin
            count <= count + 1'b1;
            tick  <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/riscv_mtimer_ctrl.sv
// riscv_mtimer_ctrl: mtime prescaler, mtimecmp compare and 32-bit register port.
// Optional RISCV_MTIMER_SNAPSHOT_EN: MTIME_LO reads latch upper bits for tear-free MTIME_HI. Revision: 1.0
`default_nettype none

module riscv_mtimer_ctrl
    import riscv_mtimer_pkg::*;
#(
    parameter int COUNTER_WIDTH  = 64,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [COUNTER_WIDTH-1:0] mtime_i,
    output logic                     tick_o,
    input  logic                     reg_valid,
    output logic                     reg_ready,
    input  logic                     reg_write,
    input  logic [4:0]               reg_addr,
    input  logic [31:0]              reg_wdata,
    output logic                     reg_rvalid,
    output logic [31:0]              reg_rdata,
    output logic                     timer_irq
);

    ctrl_t                     ctrl;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic [COUNTER_WIDTH-1:0]  mtimecmp;
    logic [63:0]               mtime_ext;
    logic [63:0]               cmp_ext;
    logic [63:0]               cmp_next;
    logic [4:0]                word_addr;
    logic                      accept;
    logic                      wr_en;
    logic                      rd_en;
    logic                      prescale_clear;
    logic [31:0]               rd_value;
    logic                      unused_addr_bits;
`ifdef RISCV_MTIMER_SNAPSHOT_EN
    logic [31:0]               mtime_shadow;
`endif

    assign reg_ready        = !reg_rvalid;
    assign accept           = reg_valid && reg_ready;
    assign wr_en            = accept && reg_write;
    assign rd_en            = accept && !reg_write;
    assign word_addr        = {reg_addr[4:2], 2'b00};
    assign unused_addr_bits = &{1'b0, reg_addr[1:0]};
    assign mtime_ext        = 64'(mtime_i);
    assign cmp_ext          = 64'(mtimecmp);

    // disabling TICK_EN clears the prescaler at the write edge so no tick escapes afterwards
    assign prescale_clear = wr_en && ((word_addr == ADDR_PRESCALE) ||
                            ((word_addr == ADDR_CTRL) && !reg_wdata[CTRL_TICK_EN_BIT]));

    always_comb begin
        cmp_next = cmp_ext;
        if (word_addr == ADDR_MTIMECMP_LO) cmp_next[31:0]  = reg_wdata;
        if (word_addr == ADDR_MTIMECMP_HI) cmp_next[63:32] = reg_wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl     <= '0;
            prescale <= '0;
            mtimecmp <= '1;
        end else if (wr_en) begin
            case (word_addr)
                ADDR_CTRL: begin
                    ctrl.tick_en <= reg_wdata[CTRL_TICK_EN_BIT];
                    ctrl.irq_en  <= reg_wdata[CTRL_IRQ_EN_BIT];
                end
                ADDR_PRESCALE:    prescale <= reg_wdata[PRESCALE_WIDTH-1:0];
                ADDR_MTIMECMP_LO,
                ADDR_MTIMECMP_HI: mtimecmp <= cmp_next[COUNTER_WIDTH-1:0];
                default: ;
            endcase
        end
    end

`ifdef RISCV_MTIMER_SNAPSHOT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mtime_shadow <= '0;
        end else if (rd_en && (word_addr == ADDR_MTIME_LO)) begin
            mtime_shadow <= mtime_ext[63:32];
        end
    end
`endif

    always_comb begin
        rd_value = '0;
        case (word_addr)
            ADDR_CTRL: begin
                rd_value[CTRL_TICK_EN_BIT] = ctrl.tick_en;
                rd_value[CTRL_IRQ_EN_BIT]  = ctrl.irq_en;
            end
            ADDR_PRESCALE:    rd_value = 32'(prescale);
            ADDR_MTIMECMP_LO: rd_value = cmp_ext[31:0];
            ADDR_MTIMECMP_HI: rd_value = cmp_ext[63:32];
            ADDR_MTIME_LO:    rd_value = mtime_ext[31:0];
`ifdef RISCV_MTIMER_SNAPSHOT_EN
            ADDR_MTIME_HI:    rd_value = mtime_shadow;
`else
            ADDR_MTIME_HI:    rd_value = mtime_ext[63:32];
`endif
            default:          rd_value = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_rvalid <= 1'b0;
            reg_rdata  <= '0;
            timer_irq  <= 1'b0;
        end else begin
            reg_rvalid <= rd_en;
            reg_rdata  <= rd_en ? rd_value : 32'h0;
            timer_irq  <= ctrl.irq_en && (mtime_i >= mtimecmp);
        end
    end

    riscv_prescaler #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (ctrl.tick_en),
        .divider (prescale),
        .clear   (prescale_clear),
        .tick    (tick_o)
    );

endmodule

`default_nettype wire
